// File: rtl/ex_stage.sv
// Execute stage: DX operand register with EX/WB forwarding feeding an external function unit, plus the EX/MEM register.
// Optional status register {V,C,N,Z} is built when EX_FLAGS_EN is defined.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic        flush,
    input  logic [3:0]  id_fs,
    input  logic [4:0]  id_sh,
    input  logic [4:0]  id_aa,
    input  logic [4:0]  id_ba,
    input  logic [4:0]  id_da,
    input  logic        id_rw,
    input  logic        id_sf,
    input  logic [31:0] id_a,
    input  logic [31:0] id_b,
    output logic [3:0]  fu_fs,
    output logic [4:0]  fu_sh,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    input  logic [31:0] fu_f,
    input  logic        fu_v,
    input  logic        fu_c,
    input  logic        fu_n,
    input  logic        fu_z,
    output logic        ex_valid,
    output logic [31:0] ex_f,
    output logic [4:0]  ex_da,
    output logic        ex_rw,
    input  logic        mem_ready,
    input  logic        wb_rw,
    input  logic [4:0]  wb_da,
    input  logic [31:0] wb_d,
    output logic [3:0]  ex_flags
);

    logic        dx_valid_r;
    logic [3:0]  dx_fs_r;
    logic [4:0]  dx_sh_r;
    logic [4:0]  dx_aa_r;
    logic [4:0]  dx_ba_r;
    logic [4:0]  dx_da_r;
    logic        dx_rw_r;
    logic        dx_sf_r;
    logic [31:0] dx_a_r;
    logic [31:0] dx_b_r;

    logic        ex_valid_r;
    logic [31:0] ex_f_r;
    logic [4:0]  ex_da_r;
    logic        ex_rw_r;

    logic        x_adv_s;
    logic        accept_s;
    logic [31:0] fwd_a_s;
    logic [31:0] fwd_b_s;

    // EX/MEM wins over WB because it holds the younger result; register 0 never forwards.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] stored,
        input logic        e_valid,
        input logic        e_rw,
        input logic [4:0]  e_da,
        input logic [31:0] e_f,
        input logic        w_rw,
        input logic [4:0]  w_da,
        input logic [31:0] w_d
    );
        logic [31:0] res;
        if ((src != 5'd0) && e_valid && e_rw && (e_da == src)) begin
            res = e_f;
        end else if ((src != 5'd0) && w_rw && (w_da == src)) begin
            res = w_d;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Handshake and forwarded operand selection.
    always_comb begin
        x_adv_s  = !ex_valid_r || mem_ready;
        id_ready = !dx_valid_r || x_adv_s;
        accept_s = id_valid && id_ready && !flush;
        fwd_a_s  = fwd_sel(dx_aa_r, dx_a_r, ex_valid_r, ex_rw_r, ex_da_r, ex_f_r, wb_rw, wb_da, wb_d);
        fwd_b_s  = fwd_sel(dx_ba_r, dx_b_r, ex_valid_r, ex_rw_r, ex_da_r, ex_f_r, wb_rw, wb_da, wb_d);
    end

    assign fu_fs    = dx_fs_r;
    assign fu_sh    = dx_sh_r;
    assign fu_a     = fwd_a_s;
    assign fu_b     = fwd_b_s;
    assign ex_valid = ex_valid_r;
    assign ex_f     = ex_f_r;
    assign ex_da    = ex_da_r;
    assign ex_rw    = ex_rw_r;

    // DX register: flush kills the held op; a stalled op keeps refreshing operands so a passing WB value sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_valid_r <= 1'b0;
            dx_fs_r    <= 4'd0;
            dx_sh_r    <= 5'd0;
            dx_aa_r    <= 5'd0;
            dx_ba_r    <= 5'd0;
            dx_da_r    <= 5'd0;
            dx_rw_r    <= 1'b0;
            dx_sf_r    <= 1'b0;
            dx_a_r     <= 32'd0;
            dx_b_r     <= 32'd0;
        end else if (flush) begin
            dx_valid_r <= 1'b0;
        end else if (accept_s) begin
            dx_valid_r <= 1'b1;
            dx_fs_r    <= id_fs;
            dx_sh_r    <= id_sh;
            dx_aa_r    <= id_aa;
            dx_ba_r    <= id_ba;
            dx_da_r    <= id_da;
            dx_rw_r    <= id_rw;
            dx_sf_r    <= id_sf;
            dx_a_r     <= id_a;
            dx_b_r     <= id_b;
        end else if (dx_valid_r && x_adv_s) begin
            dx_valid_r <= 1'b0;
        end else if (dx_valid_r) begin
            dx_a_r     <= fwd_a_s;
            dx_b_r     <= fwd_b_s;
        end else begin
            dx_valid_r <= dx_valid_r;
        end
    end

    // EX/MEM register: advances only when downstream can take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_f_r     <= 32'd0;
            ex_da_r    <= 5'd0;
            ex_rw_r    <= 1'b0;
        end else if (x_adv_s) begin
            if (dx_valid_r) begin
                ex_valid_r <= 1'b1;
                ex_f_r     <= fu_f;
                ex_da_r    <= dx_da_r;
                ex_rw_r    <= dx_rw_r;
            end else begin
                ex_valid_r <= 1'b0;
            end
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

`ifdef EX_FLAGS_EN
    logic [3:0] flags_r;

    // Status register captures the unit's flags only for flag-setting ops leaving DX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (dx_valid_r && x_adv_s && dx_sf_r) begin
            flags_r <= {fu_v, fu_c, fu_n, fu_z};
        end else begin
            flags_r <= flags_r;
        end
    end

    assign ex_flags = flags_r;
`else
    logic unused_flags_s;

    assign unused_flags_s = ^{dx_sf_r, fu_v, fu_c, fu_n, fu_z};
    assign ex_flags       = 4'b0000;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for the streaming path plus hand sequences for stall, WB forward, flags, flush and reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready, flush;
    logic [3:0]  id_fs;
    logic [4:0]  id_sh, id_aa, id_ba, id_da;
    logic        id_rw, id_sf;
    logic [31:0] id_a, id_b;
    logic [3:0]  fu_fs;
    logic [4:0]  fu_sh;
    logic [31:0] fu_a, fu_b, fu_f;
    logic        fu_v, fu_c, fu_n, fu_z;
    logic        ex_valid;
    logic [31:0] ex_f;
    logic [4:0]  ex_da;
    logic        ex_rw, mem_ready, wb_rw;
    logic [4:0]  wb_da;
    logic [31:0] wb_d;
    logic [3:0]  ex_flags;
    logic [32:0] sum33;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .flush(flush),
        .id_fs(id_fs), .id_sh(id_sh), .id_aa(id_aa), .id_ba(id_ba), .id_da(id_da),
        .id_rw(id_rw), .id_sf(id_sf), .id_a(id_a), .id_b(id_b),
        .fu_fs(fu_fs), .fu_sh(fu_sh), .fu_a(fu_a), .fu_b(fu_b), .fu_f(fu_f),
        .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
        .ex_valid(ex_valid), .ex_f(ex_f), .ex_da(ex_da), .ex_rw(ex_rw), .mem_ready(mem_ready),
        .wb_rw(wb_rw), .wb_da(wb_da), .wb_d(wb_d), .ex_flags(ex_flags)
    );

    // Reference function unit: pass A, add, sub, and, shift-left.
    always_comb begin
        sum33 = {1'b0, fu_a} + {1'b0, fu_b};
        fu_c  = 1'b0;
        fu_v  = 1'b0;
        case (fu_fs)
            4'b0000: fu_f = fu_a;
            4'b0010: begin
                fu_f = sum33[31:0];
                fu_c = sum33[32];
                fu_v = (fu_a[31] == fu_b[31]) && (sum33[31] != fu_a[31]);
            end
            4'b0101: fu_f = fu_a - fu_b;
            4'b1000: fu_f = fu_a & fu_b;
            4'b1100: fu_f = fu_a << fu_sh;
            default: fu_f = 32'd0;
        endcase
        fu_n = fu_f[31];
        fu_z = (fu_f == 32'd0);
    end

    typedef struct {
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic [4:0]  aa;
        logic [4:0]  ba;
        logic [4:0]  da;
        logic        rw;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_fa;
        logic [31:0] exp_f;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] fs, input logic [4:0] sh, input logic [4:0] aa,
                         input logic [4:0] ba, input logic [4:0] da, input logic rw,
                         input logic sf, input logic [31:0] a, input logic [31:0] b);
        id_valid = 1'b1;
        id_fs = fs; id_sh = sh; id_aa = aa; id_ba = ba; id_da = da;
        id_rw = rw; id_sf = sf; id_a = a; id_b = b;
    endtask

    logic [3:0] exp_flags;

    initial begin
`ifdef EX_FLAGS_EN
        exp_flags = 4'b1010;
`else
        exp_flags = 4'b0000;
`endif
        vecs[0] = '{4'b0010, 5'd0, 5'd1,  5'd2,  5'd3,  1'b1, 32'd5,          32'd7,      32'd5,          32'd12};
        vecs[1] = '{4'b0010, 5'd0, 5'd3,  5'd4,  5'd5,  1'b1, 32'd0,          32'd1,      32'd12,         32'd13};
        vecs[2] = '{4'b0101, 5'd0, 5'd6,  5'd5,  5'd7,  1'b1, 32'd100,        32'd0,      32'd100,        32'd87};
        vecs[3] = '{4'b0000, 5'd0, 5'd8,  5'd9,  5'd0,  1'b1, 32'h000000FF,   32'd0,      32'h000000FF,   32'h000000FF};
        vecs[4] = '{4'b0010, 5'd0, 5'd0,  5'd0,  5'd10, 1'b0, 32'h00000011,   32'd1,      32'h00000011,   32'h00000012};
        vecs[5] = '{4'b1000, 5'd0, 5'd11, 5'd12, 5'd10, 1'b0, 32'h0000F0F0,   32'h0000FF00, 32'h0000F0F0, 32'h0000F000};
        vecs[6] = '{4'b1100, 5'd4, 5'd10, 5'd12, 5'd14, 1'b0, 32'd1,          32'd0,      32'd1,          32'h00000010};
        vecs[7] = '{4'b0010, 5'd0, 5'd13, 5'd14, 5'd15, 1'b0, 32'hFFFFFFFF,   32'd1,      32'hFFFFFFFF,   32'd0};

        rst = 1'b1; flush = 1'b0; mem_ready = 1'b1;
        wb_rw = 1'b0; wb_da = 5'd0; wb_d = 32'd0;
        issue(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        id_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_f", ex_f, 32'd0);
        chk("rst_ex_da", {27'd0, ex_da}, 32'd0);
        chk("rst_ex_flags", {28'd0, ex_flags}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        rst = 1'b0;

        // Streaming vectors: op i sits in DX at negedge i+1 and in EX/MEM at negedge i+2.
        for (int i = 0; i <= NV + 1; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("vec_ex_valid", {31'd0, ex_valid}, 32'd1);
                chk("vec_ex_f", ex_f, vecs[i-2].exp_f);
                chk("vec_ex_da", {27'd0, ex_da}, {27'd0, vecs[i-2].da});
            end
            if (i >= 1 && i <= NV) begin
                chk("vec_fu_a", fu_a, vecs[i-1].exp_fa);
            end
            if (i < NV) begin
                issue(vecs[i].fs, vecs[i].sh, vecs[i].aa, vecs[i].ba, vecs[i].da,
                      vecs[i].rw, 1'b0, vecs[i].a, vecs[i].b);
            end else begin
                id_valid = 1'b0;
            end
        end

        // Stall with DX and EX/MEM both full.
        issue(4'b0010, 5'd0, 5'd16, 5'd17, 5'd18, 1'b0, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        issue(4'b0010, 5'd0, 5'd16, 5'd17, 5'd18, 1'b0, 1'b0, 32'd2, 32'd3);
        @(negedge clk);
        mem_ready = 1'b0;
        issue(4'b0010, 5'd0, 5'd16, 5'd17, 5'd18, 1'b0, 1'b0, 32'd10, 32'd10);
        #1;
        chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ex_f", ex_f, 32'd2);
            chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("resume_ex_f_b", ex_f, 32'd5);
        id_valid = 1'b0;
        @(negedge clk);
        chk("resume_ex_f_c", ex_f, 32'd20);
        @(negedge clk);
        chk("resume_drain", {31'd0, ex_valid}, 32'd0);

        // A WB value seen for one stalled cycle must survive until release.
        issue(4'b0000, 5'd0, 5'd15, 5'd0, 5'd19, 1'b0, 1'b0, 32'd7, 32'd0);
        @(negedge clk);
        issue(4'b0010, 5'd0, 5'd4, 5'd0, 5'd20, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("wbfwd_ex_f_p", ex_f, 32'd7);
        id_valid = 1'b0; mem_ready = 1'b0;
        wb_rw = 1'b1; wb_da = 5'd4; wb_d = 32'h55;
        @(negedge clk);
        wb_rw = 1'b0; wb_da = 5'd0; wb_d = 32'd0;
        @(negedge clk);
        chk("wbfwd_fu_a", fu_a, 32'h55);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wbfwd_ex_f_q", ex_f, 32'h55);

        // Flags: loaded by a set-flags add, held across a non-flag op.
        issue(4'b0010, 5'd0, 5'd21, 5'd22, 5'd23, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd1);
        @(negedge clk);
        issue(4'b0010, 5'd0, 5'd21, 5'd22, 5'd23, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("flags_set", {28'd0, ex_flags}, {28'd0, exp_flags});
        chk("flags_ex_f", ex_f, 32'h80000000);
        id_valid = 1'b0;
        @(negedge clk);
        chk("flags_hold", {28'd0, ex_flags}, {28'd0, exp_flags});
        chk("flags_ex_f2", ex_f, 32'd0);

        // Flush while stalled kills the held op and the offered one.
        issue(4'b0000, 5'd0, 5'd24, 5'd0, 5'd25, 1'b0, 1'b0, 32'h33, 32'd0);
        @(negedge clk);
        issue(4'b0000, 5'd0, 5'd24, 5'd0, 5'd25, 1'b0, 1'b0, 32'h34, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0; flush = 1'b1;
        issue(4'b0000, 5'd0, 5'd24, 5'd0, 5'd25, 1'b0, 1'b0, 32'h35, 32'd0);
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_id_ready", {31'd0, id_ready}, 32'd1);
        chk("flush_ex_f_held", ex_f, 32'h33);
        chk("flush_ex_valid_held", {31'd0, ex_valid}, 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("flush_dropped", {31'd0, ex_valid}, 32'd0);

        // Asynchronous reset mid-stream, then first accept right after release.
        issue(4'b0000, 5'd0, 5'd26, 5'd0, 5'd27, 1'b1, 1'b0, 32'h66, 32'd0);
        @(negedge clk);
        issue(4'b0000, 5'd0, 5'd26, 5'd0, 5'd27, 1'b1, 1'b0, 32'h77, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_ex_f", ex_f, 32'd0);
        chk("arst_id_ready", {31'd0, id_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        issue(4'b0000, 5'd0, 5'd28, 5'd0, 5'd29, 1'b0, 1'b0, 32'h44, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        chk("post_rst_fu_a", fu_a, 32'h44);
        @(negedge clk);
        chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_ex_f", ex_f, 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
